seq_mul: RTL
============

// Module: seq_mul
// PURPOSE
//  Sequential radix-2 shift-add multiplier for the factorial datapath. Takes the
//  running product and the next factor, and returns a 2*WIDTH-bit product.
//  Sits directly upstream of the WIDTH-bit carry-lookahead adder built from 4-bit
//  lookahead blocks: drives the adder's operands and carry-in every cycle, and
//  consumes its sum and carry-out.
//  One clock; reset is asynchronous and active-high.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of 4 (matches the 4-bit CLA slices)
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        async active-high reset
//  op_start      in   1        start pulse; captures both operands
//  op_clear      in   1        sync abort/clear
//  multiplicand  in   WIDTH    operand A
//  multiplier    in   WIDTH    operand B
//  add_a         out  WIDTH    adder operand a = P[2W-1:W]
//  add_b         out  WIDTH    adder operand b = P[0] ? mcand_r : 0
//  add_ci        out  1        adder carry-in; constant 0
//  add_s         in   WIDTH    adder sum (combinational return)
//  add_co        in   1        adder carry-out
//  result        out  2*WIDTH  product; valid while op_done=1
//  busy          out  1        1 in EXEC
//  op_done       out  1        1 in DONE
// BEHAVIOUR
//  - Regs: P[2W-1:0], mcand_r[W-1:0], cnt[log2(W):0], state{IDLE,EXEC,DONE}.
//  - Reset: state=IDLE, P=0, mcand_r=0, cnt=0; result=0, busy=0, op_done=0.
//  - Priority each cycle: op_clear > op_start > iterate.
//  - op_clear in any state: next cycle state=IDLE, P=0, cnt=0.
//  - IDLE/DONE + op_start: mcand_r<=multiplicand, P<={W'b0,multiplier}, cnt<=0,
//    state<=EXEC.
//  - EXEC + op_start: ignored; the operation continues undisturbed.
//  - EXEC step: P <= {add_co, add_s, P[W-1:1]}; cnt<=cnt+1. This is a shift right
//    with the adder carry entering at bit 2W-1. When P[0]=0, add_b=0, so
//    add_s=P[2W-1:W] and add_co=0.
//  - After exactly WIDTH EXEC cycles (cnt==WIDTH-1 on the last step) -> DONE.
//  - Latency: op_start at edge N -> op_done=1 after edge N+WIDTH+1.
//  - DONE: result=P, op_done=1, held until op_start or op_clear.
//  - IDLE: result=0.
//  - Width rule: the product never overflows 2W bits. add_co is the only carry
//    path into the upper half.
//  - Back-to-back: op_start while in DONE begins a new op next cycle, op_done->0.
//  - reset mid-EXEC: immediate return to reset values; no partial result visible.
//  - add_a/add_b/add_ci are combinational from regs; no path from inputs to them.
// CONFIGURATION
//  SEQ_MUL_ZERO_SKIP_EN
//   defined:   op_start with multiplicand==0 or multiplier==0 goes straight to
//              DONE with P=0. op_done=1 after the next edge (latency 1); EXEC is
//              never entered and busy stays 0.
//   undefined: zero operands take the full WIDTH+1 latency and give result=0.
// TESTING
//  1 3*5, WIDTH=32 -> result=64'h0F; op_done=1 exactly 33 cycles after op_start;
//    busy=1 for 32 cycles.
//  2 32'hFFFFFFFF*32'hFFFFFFFF -> result=64'hFFFFFFFE_00000001 (exercises add_co).
//  3 op_start pulsed again mid-EXEC with new operands -> ignored; first result
//    (7*9=63) delivered with unchanged latency.
//  4 op_clear at cycle 10 of EXEC -> IDLE next cycle, result=0, busy=0; a new
//    op_start 12*12 then yields 144.
//  5 reset asserted mid-EXEC, async between edges -> outputs 0 immediately;
//    after release 0x10000*0x10000 = 64'h1_00000000.
//  6 0*123: with SEQ_MUL_ZERO_SKIP_EN op_done after 1 cycle, result=0; without
//    the macro op_done after 33 cycles, result=0; random 1000-vector compare
//    against the * operator.

Source files
------------

// File: rtl/seq_mul.sv
// seq_mul: sequential radix-2 shift-add multiplier driving an external WIDTH-bit CLA adder
// Ports: clk, reset (async active-high), op_start, op_clear, multiplicand, multiplier,
//        add_a/add_b/add_ci (adder operands), add_s/add_co (adder return),
//        result (2*WIDTH product, valid in DONE), busy (EXEC), op_done (DONE).
// Macro SEQ_MUL_ZERO_SKIP_EN: a zero operand at op_start goes straight to DONE with result 0.
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_ci,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_co,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               op_done
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] p, p_n;
    logic [WIDTH-1:0] mcand_r, mcand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic zero_op;
`ifdef SEQ_MUL_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            p       <= '0;
            mcand_r <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            p       <= p_n;
            mcand_r <= mcand_n;
            cnt     <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        p_n     = p;
        mcand_n = mcand_r;
        cnt_n   = cnt;
        if (op_clear) begin
            state_n = IDLE;
            p_n     = '0;
            cnt_n   = '0;
        end else if (op_start && state != EXEC) begin
            mcand_n = multiplicand;
            p_n     = zero_op ? '0 : {{WIDTH{1'b0}}, multiplier};
            cnt_n   = '0;
            state_n = zero_op ? DONE : EXEC;
        end else if (state == EXEC) begin
            // shift right; the adder carry lands in the top bit
            p_n   = {add_co, add_s, p[WIDTH-1:1]};
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
                state_n = DONE;
        end
    end
    assign add_a   = p[2*WIDTH-1:WIDTH];
    assign add_b   = p[0] ? mcand_r : '0;
    assign add_ci  = 1'b0;
    assign result  = (state == DONE) ? p : '0;
    assign busy    = (state == EXEC);
    assign op_done = (state == DONE);
endmodule
